// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Bit-step counter width; WIDTH-1 is the largest value it ever holds.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor cell: x - y - bin.
module serial_sub_fs (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  // Difference bit and borrow-out of a single bit position.
  assign o_d    = i_x ^ i_y ^ i_bin;
  assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per clock, registered borrow.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] d_sh_q;   // upper difference bits gathered so far
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] diff_full;
  logic             last_step;

  serial_sub_fs u_fs (
    .i_x    (a_sh_q[0]),
    .i_y    (b_sh_q[0]),
    .i_bin  (borrow_q),
    .o_d    (fs_d),
    .o_bout (fs_bout)
  );

  // Current difference bit enters at the MSB; on the last step this is the full result.
  assign diff_full = {fs_d, d_sh_q};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Control FSM, operand/result shifters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      d_sh_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            a_sh_q   <= i_a;
            b_sh_q   <= i_b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          d_sh_q   <= diff_full[WIDTH-1:1];
          borrow_q <= fs_bout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_step) begin
            // Counter parks at zero so it never runs past WIDTH-1.
            cnt_q        <= '0;
            diff_q       <= diff_full;
            borrow_out_q <= fs_bout;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_diff   = diff_q;
  assign o_borrow = borrow_out_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub with a result scoreboard.
module tb_serial_sub;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH:0]   sb_q[$];
  logic [WIDTH:0]   last_exp = '0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_diff   (diff),
    .o_borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every completed result against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        last_exp = sb_q.pop_front();
        check("diff", 32'(diff), 32'(last_exp[WIDTH-1:0]));
        check("borrow", 32'(borrow), 32'(last_exp[WIDTH]));
      end
    end
  end

  // Drive a start request at the current negedge and record the expected result.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    logic [WIDTH:0] exp;
    start = 1'b1;
    a     = av;
    b     = bv;
    exp   = {1'b0, av} - {1'b0, bv};
    sb_q.push_back(exp);
  endtask

  // Follow an accepted op to its done pulse; checks busy length and latency.
  // glitch: pulse start and scramble operands mid-run.
  task automatic wait_done(input bit glitch);
    int busy_cnt = 0;
    int lat      = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (glitch && n == 3) begin
        start = 1'b1;
        a     = 8'($urandom);
        b     = 8'($urandom);
      end
      if (glitch && n == 4) start = 1'b0;
      if (n == 4) check("hold_during_run", 32'({borrow, diff}), 32'(last_exp));
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("done_latency", 32'(lat), 32'd8);
    check("busy_cycles", 32'(busy_cnt), 32'd8);
  endtask

  task automatic run_dir(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [WIDTH-1:0] ed, input logic eb);
    @(negedge clk);
    start_op(av, bv);
    wait_done(1'b0);
    check("dir_diff", 32'(diff), 32'(ed));
    check("dir_borrow", 32'(borrow), 32'(eb));
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2 rst_n = 1'b0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
      #1;
      check("rst_outputs", 32'({busy, done, borrow, diff}), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_hold", 32'({busy, done}), 32'd0);
    end

    // Directed cases.
    run_dir(8'h5A, 8'h23, 8'h37, 1'b0);
    run_dir(8'h00, 8'h01, 8'hFF, 1'b1);
    run_dir(8'h80, 8'h7F, 8'h01, 1'b0);
    run_dir(8'hFF, 8'hFF, 8'h00, 1'b0);

    // Result holds through idle cycles.
    repeat (3) @(negedge clk);
    check("hold_idle", 32'({borrow, diff}), 32'h000);

    // Mid-run start/operand changes ignored, then back-to-back from DONE.
    @(negedge clk);
    start_op(8'h9C, 8'h41);
    wait_done(1'b1);
    check("glitch_diff", 32'(diff), 32'h5B);
    start_op(8'h10, 8'h20);
    wait_done(1'b0);
    check("b2b_diff", 32'(diff), 32'hF0);
    check("b2b_borrow", 32'(borrow), 32'd1);

    // Reset during the 4th RUN cycle of 0x00-0xFF.
    @(negedge clk);
    start_op(8'h00, 8'hFF);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({busy, done, borrow, diff}), 32'd0);
    void'(sb_q.pop_back());
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_dir(8'h05, 8'h03, 8'h02, 1'b0);

    // Random operands with random idle gaps.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      start_op(8'($urandom), 8'($urandom));
      wait_done(1'b0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial WIDTH-bit unsigned subtractor; the inverse-direction companion to the team's full-adder datapath.
- Operands are captured on a start request and processed LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow.
- It produces the difference, a borrow-out and a one-cycle done pulse.
- It is used where area matters more than latency, for example in counter/compare paths next to the adder blocks.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  reset; asynchronous assert, active-low
i_start  input  1  start request; sampled only in IDLE or DONE
i_a  input  WIDTH  minuend; sampled only on the accepting edge
i_b  input  WIDTH  subtrahend; sampled only on the accepting edge
o_busy  output  1  high while bits are being processed (RUN)
o_done  output  1  one-cycle pulse: o_diff/o_borrow just updated
o_diff  output  WIDTH  (i_a - i_b) mod 2^WIDTH of last completed op
o_borrow  output  1  1 iff i_a < i_b (unsigned) for last completed op

Behaviour:
- Interface: one clock domain, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: state IDLE; o_busy=0, o_done=0, o_diff=0, o_borrow=0. Internal shift registers, bit counter and borrow flop are all cleared to 0.
- States:
  - IDLE: if i_start=1, go to RUN. Otherwise stay.
  - RUN: go to DONE after WIDTH bit-steps. Otherwise stay.
  - DONE (exactly one cycle): if i_start=1, go to RUN (back-to-back). Otherwise go to IDLE.
- Accepting edge (IDLE or DONE with i_start=1):
  - Load a_sh<=i_a, b_sh<=i_b.
  - Set borrow<=0 and cnt<=0.
- RUN bit-step, one per edge:
  - Full subtractor inputs: x=a_sh[0], y=b_sh[0], bin=borrow.
  - d = x^y^bin.
  - bout = (~x&y) | (~(x^y)&bin).
  - Shift d into the MSB of d_sh (right shift).
  - a_sh and b_sh shift right by one.
  - borrow<=bout; cnt<=cnt+1.
- Last step (cnt==WIDTH-1):
  - o_diff <= final d_sh, including the current d.
  - o_borrow <= bout.
  - o_done <= 1; state <= DONE.
- Latency:
  - o_busy is high for exactly WIDTH cycles, starting the cycle after the accepting edge.
  - o_done is high for the single cycle following the WIDTH-th RUN edge, i.e. WIDTH edges after the accepting edge.
- Output holding:
  - o_diff/o_borrow change only on the last RUN edge, or on reset.
  - They hold their value through IDLE and through a following operation until that operation completes.
- i_start during RUN is ignored. There is no queuing, and i_a/i_b changes during RUN have no effect.
- Wrap-around: the result is modulo 2^WIDTH. o_borrow is the only overflow indication, and there is no sign interpretation.
- Reset mid-RUN:
  - Aborts immediately; all outputs return to 0 and state goes to IDLE.
  - The next accepted op starts with borrow=0 and its result is unaffected by the aborted one.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1.

Decomposition:
- Package serial_sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - function/localparam for the counter width CNT_W = $clog2(WIDTH).
- Sub-module fs: combinational 1-bit full subtractor.
  - Inputs i_x, i_y, i_bin; outputs o_d, o_bout.
  - One instance inside serial_sub.

Test Plan:
- Reset asserted with random inputs toggling -> o_busy=0, o_done=0, o_diff=0x00, o_borrow=0; after release, IDLE holds while i_start=0.
- WIDTH=8, i_a=0x5A, i_b=0x23, one-cycle i_start -> o_busy high 8 cycles; o_done pulses 8 edges after accept; o_diff=0x37, o_borrow=0.
- i_a=0x00, i_b=0x01 -> o_diff=0xFF, o_borrow=1 (borrow ripples all 8 bits); then i_a=0x80, i_b=0x7F -> o_diff=0x01, o_borrow=0; i_a=i_b=0xFF -> 0x00, 0.
- i_start pulsed and i_a/i_b changed mid-RUN -> ignored, result of the original op unchanged; i_start held high in the DONE cycle with 0x10-0x20 -> accepted back-to-back, o_diff=0xF0, o_borrow=1 after 8 more edges.
- i_rst_n asserted at the 4th RUN cycle of 0x00-0xFF (borrow flop=1) -> immediate outputs 0, IDLE; next op 0x05-0x03 -> o_diff=0x02, o_borrow=0.
- 1000 random (i_a, i_b) pairs with random idle gaps -> every o_done matches the model {o_borrow,o_diff} = {1'b0,a} - {1'b0,b} (9-bit), and o_borrow equals bit 8.
